// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults for the fifo slice.
//               c_WIDTH : default data word width (bits)
//               c_DEPTH : default number of storage entries (power of two)
//               word_t  : data word at the default width
// Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned c_WIDTH = 16;
    localparam int unsigned c_DEPTH = 8;

    typedef logic [c_WIDTH-1:0] word_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x WIDTH storage array. Synchronous write port and a
//               registered read port. The read register is zeroed by the
//               asynchronous reset and by the synchronous clear, and holds
//               its value on cycles without rd_en. Array contents are never
//               reset.
//   clock    in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset
//   clear    in   1      synchronous clear of the read register
//   wr_en    in   1      write wr_data to wr_addr
//   wr_addr  in   AW     write address
//   wr_data  in   WIDTH  write data
//   rd_en    in   1      load rd_data from rd_addr
//   rd_addr  in   AW     read address
//   rd_data  out  WIDTH  registered read data
// Revision    : 1.0  initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH,
    parameter int unsigned DEPTH = c_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage has no reset so it can map onto plain RAM cells.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (clear) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Single-clock FIFO with independent write/read enables,
//               full/empty flags and a synchronous flush. Read data is
//               registered (one clock latency, no fall-through).
//   clock     in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   clear     in   1      synchronous flush, active high
//   write     in   1      push data_in this cycle
//   read      in   1      pop head word to data_out this cycle
//   data_in   in   WIDTH  write data
//   full      out  1      count == DEPTH
//   empty     out  1      count == 0
//   data_out  out  WIDTH  registered read data, holds between reads
// Revision    : 1.0  initial release
// ============================================================================
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH,
    parameter int unsigned DEPTH = c_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;

    // Flags decode the count register only, so they never follow input glitches.
    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A pop frees a slot in the same edge, so a full FIFO still accepts a
    // write when a read is accepted alongside it.
    assign w_rd_ok = read & ~w_empty;
    assign w_wr_ok = write & (~w_full | w_rd_ok);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Clear takes priority over read/write, so both ports are masked here.
    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (w_wr_ok & ~clear),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_en   (w_rd_ok & ~clear),
        .rd_addr (r_rd_ptr),
        .rd_data (data_out)
    );

    assign full  = w_full;
    assign empty = w_empty;

endmodule : fifo
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo
// Description : Directed self-checking bench for fifo (WIDTH=16, DEPTH=8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo;
    import fifo_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  clear;
    logic  write;
    logic  read;
    word_t data_in;
    logic  full;
    logic  empty;
    word_t data_out;

    int n_cmp;
    int n_err;

    fifo #(
        .WIDTH (16),
        .DEPTH (8)
    ) dut (
        .clock    (clk),
        .reset    (rst_n),
        .clear    (clear),
        .write    (write),
        .read     (read),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input word_t d);
        write   = 1'b1;
        data_in = d;
        step();
        write   = 1'b0;
    endtask

    task automatic pop_check(input string tag, input word_t exp);
        read = 1'b1;
        step();
        read = 1'b0;
        check(tag, 32'(data_out), 32'(exp));
    endtask

    word_t stream [10] = '{16'd100, 16'd150, 16'd200, 16'd40, 16'd70,
                           16'd65, 16'd15, 16'd230, 16'd150, 16'd200};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        clear   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;

        // 1: reset state
        step();
        step();
        rst_n = 1'b1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);

        // 1b: asynchronous reset mid-stream
        push(16'd5);
        push(16'd6);
        pop_check("mid_rd", 16'd5);
        check("mid_empty_pre", 32'(empty), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_empty_async", 32'(empty), 32'd1);
        check("mid_dout_async", 32'(data_out), 32'd0);
        step();
        rst_n = 1'b1;

        // 2: three writes, four reads; last read ignored
        push(16'd100);
        push(16'd150);
        push(16'd200);
        pop_check("t2_rd0", 16'd100);
        check("t2_empty0", 32'(empty), 32'd0);
        pop_check("t2_rd1", 16'd150);
        check("t2_empty1", 32'(empty), 32'd0);
        pop_check("t2_rd2", 16'd200);
        check("t2_empty2", 32'(empty), 32'd1);
        pop_check("t2_rd3_hold", 16'd200);
        check("t2_empty3", 32'(empty), 32'd1);

        // 3: fill to full, overflow write dropped, drain in order
        for (int i = 1; i <= 8; i++) begin
            push(word_t'(i));
            check($sformatf("t3_full_%0d", i), 32'(full), (i == 8) ? 32'd1 : 32'd0);
        end
        push(16'd99);
        check("t3_full_ovf", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop_check($sformatf("t3_rd_%0d", i), word_t'(i));
        end
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_full_end", 32'(full), 32'd0);

        // 4: clear flushes; write/read asserted with it are ignored
        push(16'd10);
        push(16'd20);
        push(16'd30);
        clear   = 1'b1;
        write   = 1'b1;
        read    = 1'b1;
        data_in = 16'd77;
        step();
        clear = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        check("t4_empty", 32'(empty), 32'd1);
        check("t4_dout", 32'(data_out), 32'd0);
        push(16'd40);
        pop_check("t4_rd", 16'd40);
        check("t4_empty_end", 32'(empty), 32'd1);

        // 5: streaming with read starting 3 cycles after write
        for (int t = 0; t < 13; t++) begin
            write   = (t < 10);
            data_in = (t < 10) ? stream[t] : '0;
            read    = (t >= 3);
            step();
            if (t >= 3) begin
                check($sformatf("t5_rd_%0d", t - 3), 32'(data_out), 32'(stream[t-3]));
            end
            if (t >= 2 && t < 10) begin
                check($sformatf("t5_nonempty_%0d", t), 32'(empty), 32'd0);
            end
        end
        write = 1'b0;
        read  = 1'b0;
        check("t5_empty", 32'(empty), 32'd1);

        // 5b: empty plus read+write: only the write lands, data_out holds
        write   = 1'b1;
        read    = 1'b1;
        data_in = 16'd55;
        step();
        write = 1'b0;
        read  = 1'b0;
        check("t5b_hold", 32'(data_out), 32'd200);
        check("t5b_empty", 32'(empty), 32'd0);
        pop_check("t5b_rd", 16'd55);

        // 6: full plus read+write
        for (int i = 0; i < 8; i++) begin
            push(word_t'(11 + i));
        end
        check("t6_full_pre", 32'(full), 32'd1);
        write   = 1'b1;
        read    = 1'b1;
        data_in = 16'd19;
        step();
        write = 1'b0;
        read  = 1'b0;
        check("t6_head", 32'(data_out), 32'd11);
        check("t6_full_post", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop_check($sformatf("t6_rd_%0d", i), word_t'(12 + i));
        end
        check("t6_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo
`default_nettype wire
